matrix_mul_seq_ctrl: RTL and testbench



---
 rtl/matrix_mul_seq_ctrl.sv | 90 +++++++++
 tb/tb_matrix_mul_seq_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/matrix_mul_seq_ctrl.sv
// matrix_mul_seq_ctrl: 3x3 matrix product C = A x B computed with one shared MAC, 27 cycles per product.
// Define MATMUL_SAT_EN to saturate result elements at 2^DW-1 instead of truncating.
module matrix_mul_seq_ctrl #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [9*DW-1:0] a,
    input  logic [9*DW-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [9*DW-1:0] c
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DN   = 2'd2;
    logic [1:0]        state, i, j, k;
    logic [2*DW+1:0]   acc, sum;
    logic [9*DW-1:0]   ra, rb, shadow, shadow_nxt;
    logic [DW-1:0]     ma [9];
    logic [DW-1:0]     mb [9];
    logic [DW-1:0]     res;
    logic [2*DW-1:0]   prod;
    logic [3:0]        ia, ib, ic;
    logic              last;
    always_comb begin
        for (int n = 0; n < 9; n++) begin
            ma[n] = ra[(8-n)*DW +: DW];
            mb[n] = rb[(8-n)*DW +: DW];
        end
        ia = 4'(3 * i + k);
        ib = 4'(3 * k + j);
        ic = 4'(3 * i + j);
        prod = ma[ia] * mb[ib];
        sum = acc + {2'b00, prod};
`ifdef MATMUL_SAT_EN
        res = |sum[2*DW+1:DW] ? '1 : sum[DW-1:0];
`else
        res = sum[DW-1:0];
`endif
        shadow_nxt = shadow;
        shadow_nxt[(4'd8 - ic)*DW +: DW] = res;
        last = (i == 2'd2) && (j == 2'd2) && (k == 2'd2);
    end
    assign busy = (state == RUN);
    assign done = (state == DN);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
            shadow <= '0;
            ra     <= '0;
            rb     <= '0;
            c      <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                ra     <= a;
                rb     <= b;
                i      <= '0;
                j      <= '0;
                k      <= '0;
                acc    <= '0;
                shadow <= '0;
                state  <= RUN;
            end
        end else if (state == RUN) begin
            if (k != 2'd2) begin
                acc <= sum;
                k   <= k + 2'd1;
            end else begin
                shadow <= shadow_nxt;
                acc    <= '0;
                k      <= '0;
                j      <= (j == 2'd2) ? 2'd0 : j + 2'd1;
                i      <= (j != 2'd2) ? i : (i == 2'd2) ? 2'd0 : i + 2'd1;
                // final element goes straight to c so it is visible in the DONE cycle
                if (last) begin
                    c     <= shadow_nxt;
                    state <= DN;
                end
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_matrix_mul_seq_ctrl.sv
// tb_matrix_mul_seq_ctrl: scoreboard bench for matrix_mul_seq_ctrl; honours MATMUL_SAT_EN.
module tb_matrix_mul_seq_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [71:0] a = '0;
    logic [71:0] b = '0;
    logic        busy, done;
    logic [71:0] c;
    logic [71:0] q [$];
    logic [71:0] c_prev = '0;
    int          pass_cnt = 0;
    int          total = 0;

    matrix_mul_seq_ctrl #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .c(c)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] seq(input int first, input int step);
        logic [71:0] r;
        for (int n = 0; n < 9; n++) r[(8-n)*8 +: 8] = 8'(first + step * n);
        return r;
    endfunction

    function automatic logic [71:0] matmul(input logic [71:0] x, input logic [71:0] y);
        logic [71:0] r;
        int s;
        for (int p = 0; p < 3; p++)
            for (int q2 = 0; q2 < 3; q2++) begin
                s = 0;
                for (int m = 0; m < 3; m++)
                    s += int'(x[(8-(3*p+m))*8 +: 8]) * int'(y[(8-(3*m+q2))*8 +: 8]);
`ifdef MATMUL_SAT_EN
                if (s > 255) s = 255;
`endif
                r[(8-(3*p+q2))*8 +: 8] = 8'(s);
            end
        return r;
    endfunction

    task automatic issue(input logic [71:0] ia, input logic [71:0] ib, input logic [71:0] exp, input bit push);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1;
        if (push) q.push_back(exp);
        @(posedge clk);
    endtask

    // n counts edges after the accepting edge T; sample n sits in cycle T+n
    task automatic track(input string name, input int ignore_at, input bit scramble);
        logic [71:0] exp;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            start = (n == ignore_at);
            if (scramble && n == 3) begin
                a = 72'({$urandom(), $urandom(), $urandom()});
                b = 72'({$urandom(), $urandom(), $urandom()});
            end
            total++;
            if (busy !== (n <= 27)) $display("FAIL %s busy cycle T+%0d: got %b want %b", name, n, busy, n <= 27);
            else pass_cnt++;
            total++;
            if (done !== (n == 28)) $display("FAIL %s done cycle T+%0d: got %b want %b", name, n, done, n == 28);
            else pass_cnt++;
            total++;
            if (n == 28) begin
                exp = (q.size() > 0) ? q.pop_front() : 'x;
                if (c !== exp) $display("FAIL %s result: got %h want %h", name, c, exp);
                else pass_cnt++;
                c_prev = exp;
            end else if (c !== c_prev) $display("FAIL %s hold cycle T+%0d: got %h want %h", name, n, c, c_prev);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, c} !== 74'd0) $display("FAIL reset: got busy=%b done=%b c=%h want all zero", busy, done, c);
        else pass_cnt++;
        rst_n = 1;
    endtask

    task automatic test_values;
        issue(seq(1, 1), seq(9, -1), {8'd30, 8'd24, 8'd18, 8'd84, 8'd69, 8'd54, 8'd138, 8'd114, 8'd90}, 1);
        track("values", 0, 0);
        start = 0;
    endtask

    task automatic test_identity_ignore;
        issue(72'h01_00_00_00_01_00_00_00_01, seq(1, 1), seq(1, 1), 1);
        track("identity", 5, 0);
        start = 0;
    endtask

    task automatic test_saturation;
        issue({9{8'd1}}, {9{8'd1}}, {9{8'd3}}, 1);
        track("ones", 0, 0);
        start = 0;
`ifdef MATMUL_SAT_EN
        issue({72{1'b1}}, {72{1'b1}}, {9{8'd255}}, 1);
`else
        issue({72{1'b1}}, {72{1'b1}}, {9{8'd3}}, 1);
`endif
        track("max", 0, 0);
        start = 0;
    endtask

    task automatic test_mid_reset;
        issue(seq(2, 3), seq(5, 1), '0, 0);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 0;
        end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        total++;
        if ({busy, done, c} !== 74'd0) $display("FAIL midreset: got busy=%b done=%b c=%h want all zero", busy, done, c);
        else pass_cnt++;
        c_prev = '0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) $display("FAIL midreset idle: got busy=%b done=%b want 0 0", busy, done);
            else pass_cnt++;
        end
        issue(seq(1, 2), seq(3, 1), matmul(seq(1, 2), seq(3, 1)), 1);
        track("after_reset", 0, 0);
        start = 0;
    endtask

    task automatic test_capture;
        logic [71:0] xa, xb;
        xa = 72'({$urandom(), $urandom(), $urandom()});
        xb = 72'({$urandom(), $urandom(), $urandom()});
        issue(xa, xb, matmul(xa, xb), 1);
        track("capture", 0, 1);
        start = 0;
    endtask

    task automatic test_back_to_back;
        logic [71:0] xa, xb;
        issue(seq(9, -1), seq(1, 1), matmul(seq(9, -1), seq(1, 1)), 1);
        track("b2b_first", 28, 0);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b ignored start: got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        xa = seq(4, 7);
        xb = seq(200, 5);
        a = xa;
        b = xb;
        q.push_back(matmul(xa, xb));
        @(posedge clk);
        track("b2b_second", 0, 0);
        start = 0;
    endtask

    initial begin
        test_reset();
        test_values();
        test_identity_ignore();
        test_saturation();
        test_mid_reset();
        test_capture();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
